// File: rtl/lever_ctrl.sv
// Mouse-side control for the on-screen lever: hover hit test, button debounce
// and the click FSM that steps the lever through neutral, up and down.
module lever_ctrl #(
  parameter int LEVER_POSIT_X   = 100,
  parameter int LEVER_POSIT_Y   = 100,
  parameter int WIDTH           = 100,
  parameter int HEIGHT          = 50,
  parameter int HIGHLIGHT_RANGE = 3,
  parameter int DEBOUNCE        = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        left,
  output logic        hover,
  output logic [1:0]  lever_state,
  output logic        pulled,
  output logic        busy
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);

  // Signed bounds so a highlight margin reaching past pixel 0 cannot wrap.
  localparam logic signed [12:0] X_LO = 13'(LEVER_POSIT_X - HIGHLIGHT_RANGE);
  localparam logic signed [12:0] X_HI = 13'(LEVER_POSIT_X + WIDTH + HIGHLIGHT_RANGE);
  localparam logic signed [12:0] Y_LO = 13'(LEVER_POSIT_Y - HIGHLIGHT_RANGE);
  localparam logic signed [12:0] Y_HI = 13'(LEVER_POSIT_Y + HEIGHT + HIGHLIGHT_RANGE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic signed [12:0] x_s;
  logic signed [12:0] y_s;
  logic               hover_nxt;

  logic [CNT_W-1:0]   db_cnt;
  logic               btn_db;
  logic               btn_prev;
  logic               btn_rise;
  logic               btn_fall;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         lever_nxt;
  logic               pulled_nxt;

  assign x_s = $signed({1'b0, xpos});
  assign y_s = $signed({1'b0, ypos});
  assign hover_nxt = (x_s >= X_LO) && (x_s <= X_HI) &&
                     (y_s >= Y_LO) && (y_s <= Y_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hover <= 1'b0;
    end else begin
      hover <= hover_nxt;
    end
  end

  // btn_db flips only after DEBOUNCE consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_db;
      if (left == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        btn_db <= left;
        db_cnt <= '0;
      end else if (db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_rise = btn_db & ~btn_prev;
  assign btn_fall = ~btn_db & btn_prev;

  always_comb begin
    state_nxt  = state;
    lever_nxt  = lever_state;
    pulled_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_rise) begin
          state_nxt = hover ? PRESS : WAIT_REL;
        end
      end
      PRESS: begin
        // Losing hover wins over a simultaneous release: the click is aborted.
        if (!hover) begin
          state_nxt = btn_db ? WAIT_REL : IDLE;
        end else if (btn_fall) begin
          state_nxt  = IDLE;
          pulled_nxt = 1'b1;
          case (lever_state)
            2'b00:   lever_nxt = 2'b01;
            2'b01:   lever_nxt = 2'b10;
            default: lever_nxt = 2'b00;
          endcase
        end
      end
      WAIT_REL: begin
        if (!btn_db) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lever_state <= 2'b00;
      pulled      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      lever_state <= lever_nxt;
      pulled      <= pulled_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_lever_ctrl.sv
// Directed bench for lever_ctrl with DEBOUNCE=4; lever_state on every pulled
// pulse is checked against a queue of expected positions.
module tb_lever_ctrl;

  logic        clk;
  logic        rst;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        hover;
  logic [1:0]  lever_state;
  logic        pulled;
  logic        busy;

  int          n_checks;
  int          n_fail;
  logic [1:0]  exp_q[$];
  logic        pulled_last;

  lever_ctrl #(.DEBOUNCE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .xpos        (xpos),
    .ypos        (ypos),
    .left        (left),
    .hover       (hover),
    .lever_state (lever_state),
    .pulled      (pulled),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int x, input int y, input logic btn);
    xpos = 12'(x);
    ypos = 12'(y);
    left = btn;
  endtask

  // Full valid click at the lever centre; expects lever_state to become nxt.
  task automatic valid_click(input logic [1:0] nxt);
    apply_stimulus(150, 120, 1'b1);
    wait_cycles(4);
    check_output("busy_before_accept", busy, 0);
    wait_cycles(1);
    check_output("busy_after_press", busy, 1);
    wait_cycles(5);
    exp_q.push_back(nxt);
    apply_stimulus(150, 120, 1'b0);
    wait_cycles(4);
    check_output("pulled_early", pulled, 0);
    wait_cycles(1);
    check_output("pulled_on_time", pulled, 1);
    check_output("lever_state_click", lever_state, nxt);
    wait_cycles(1);
    check_output("pulled_one_cycle", pulled, 0);
    check_output("busy_after_click", busy, 0);
  endtask

  // Scoreboard monitor: every pulled pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst && pulled) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_pulled: got lever_state %0d, expected no pulse at %0t",
                 lever_state, $time);
      end else begin
        check_output("sb_lever_state", lever_state, exp_q.pop_front());
      end
      if (pulled_last) begin
        check_output("pulled_back_to_back", 1, 0);
      end
    end
    pulled_last <= pulled;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected test end");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    pulled_last = 1'b0;
    rst = 1'b0;
    apply_stimulus(0, 0, 1'b0);
    #1;
    check_output("reset_hover", hover, 0);
    check_output("reset_state", lever_state, 0);
    check_output("reset_pulled", pulled, 0);
    check_output("reset_busy", busy, 0);
    #22 rst = 1'b1;
    wait_cycles(2);

    apply_stimulus(97, 97, 1'b0);
    wait_cycles(1);
    check_output("hover_low_corner", hover, 1);
    apply_stimulus(96, 97, 1'b0);
    wait_cycles(1);
    check_output("hover_left_out", hover, 0);
    apply_stimulus(203, 153, 1'b0);
    wait_cycles(1);
    check_output("hover_high_corner", hover, 1);
    apply_stimulus(204, 153, 1'b0);
    wait_cycles(1);
    check_output("hover_right_out", hover, 0);
    apply_stimulus(203, 154, 1'b0);
    wait_cycles(1);
    check_output("hover_bottom_out", hover, 0);

    valid_click(2'b01);
    valid_click(2'b10);
    valid_click(2'b00);

    apply_stimulus(150, 120, 1'b1);
    wait_cycles(3);
    apply_stimulus(150, 120, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_cycles(1);
      check_output("glitch_busy", busy, 0);
      check_output("glitch_pulled", pulled, 0);
    end

    apply_stimulus(20, 20, 1'b1);
    wait_cycles(5);
    check_output("dragin_busy", busy, 1);
    apply_stimulus(150, 120, 1'b1);
    wait_cycles(4);
    check_output("dragin_busy_on_lever", busy, 1);
    apply_stimulus(150, 120, 1'b0);
    wait_cycles(4);
    check_output("dragin_busy_held", busy, 1);
    wait_cycles(1);
    check_output("dragin_pulled", pulled, 0);
    check_output("dragin_busy_done", busy, 0);
    check_output("dragin_state", lever_state, 0);

    apply_stimulus(150, 120, 1'b1);
    wait_cycles(5);
    check_output("dragout_busy", busy, 1);
    apply_stimulus(300, 300, 1'b1);
    wait_cycles(3);
    check_output("dragout_busy_wait", busy, 1);
    apply_stimulus(300, 300, 1'b0);
    wait_cycles(5);
    check_output("dragout_pulled", pulled, 0);
    check_output("dragout_busy_done", busy, 0);
    check_output("dragout_state", lever_state, 0);

    valid_click(2'b01);
    apply_stimulus(150, 120, 1'b1);
    wait_cycles(6);
    check_output("pre_reset_busy", busy, 1);
    #3 rst = 1'b0;
    #1;
    check_output("async_hover", hover, 0);
    check_output("async_state", lever_state, 0);
    check_output("async_busy", busy, 0);
    check_output("async_pulled", pulled, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(4);
    check_output("post_reset_idle", busy, 0);
    wait_cycles(1);
    check_output("post_reset_press", busy, 1);
    wait_cycles(2);
    exp_q.push_back(2'b01);
    apply_stimulus(150, 120, 1'b0);
    wait_cycles(5);
    check_output("post_reset_pulled", pulled, 1);
    check_output("post_reset_state", lever_state, 1);
    wait_cycles(3);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lever_ctrl.md
Name: lever_ctrl

Overview:
- Input-side counterpart of the on-screen lever graphic: reads mouse cursor position and left button, and decides whether the lever is hovered and whether a valid click occurred.
- Holds the lever's logical position (neutral/up/down); the lever drawing stage and game logic consume it.
- Sits between the mouse position/button registers and the draw and game-logic stages, in the 65 MHz pixel clock domain.

Parameters:
- LEVER_POSIT_X, 100, left edge of the lever rectangle in pixels.
- LEVER_POSIT_Y, 100, top edge of the lever rectangle in pixels.
- WIDTH, 100, lever width; the rectangle spans x..x+WIDTH inclusive.
- HEIGHT, 50, lever height; the rectangle spans y..y+HEIGHT inclusive.
- HIGHLIGHT_RANGE, 3, hover margin added on every side, matching the drawn highlight ring.
- DEBOUNCE, 65000, consecutive stable cycles required to accept a button level change (minimum 1).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-low.
- xpos  in  12  cursor x, already synchronous to clk.
- ypos  in  12  cursor y, already synchronous to clk.
- left  in  1  raw left mouse button, 1 = pressed.
- hover  out  1  cursor is inside the lever rectangle plus HIGHLIGHT_RANGE.
- lever_state  out  2  00 neutral, 01 up, 10 down; 11 never driven.
- pulled  out  1  one-cycle pulse when lever_state changes.
- busy  out  1  high while a press is being tracked (PRESS or WAIT_REL state).

Behaviour:
- Reset (rst low, asynchronous): hover=0, lever_state=00, pulled=0, busy=0, FSM=IDLE, btn_db=0, debounce counter=0.
- Hit test:
  - hover_nxt = xpos >= LEVER_POSIT_X-HIGHLIGHT_RANGE and xpos <= LEVER_POSIT_X+WIDTH+HIGHLIGHT_RANGE, and the same test on ypos with LEVER_POSIT_Y and HEIGHT.
  - Compare in 13-bit signed arithmetic so that a margin extending below 0 does not wrap.
  - hover is registered: 1 cycle latency from xpos/ypos.
- Debounce:
  - Counter counts up while left != btn_db and clears whenever left == btn_db.
  - When the counter reaches DEBOUNCE-1 while left != btn_db, btn_db takes the value of left on the next edge and the counter clears.
  - Net effect: btn_db follows left after exactly DEBOUNCE consecutive differing cycles.
  - Any glitch shorter than DEBOUNCE cycles produces no change in btn_db.
  - Counter width is $clog2(DEBOUNCE+1); the counter saturates and never wraps.
- FSM (uses the registered hover and btn_db; rise/fall are detected against btn_db delayed by one cycle):
  - IDLE:
    - btn_db rise with hover=1 -> PRESS.
    - btn_db rise with hover=0 -> WAIT_REL. A press that starts outside the lever never acts, even if the cursor is dragged onto it.
  - PRESS:
    - btn_db fall with hover=1 -> IDLE. On the same edge, lever_state advances 00->01->10->00 and pulled=1 for one cycle.
    - hover=0 while btn_db=1 -> WAIT_REL (click aborted, no state change).
    - If hover falls and btn_db falls in the same cycle, hover takes priority: abort, no action.
  - WAIT_REL: btn_db fall -> IDLE, no action.
- busy = 1 in PRESS and WAIT_REL; it is registered together with the state.
- Latency:
  - pulled is asserted on the edge where the FSM sees the btn_db fall.
  - Raw left release to pulled high = DEBOUNCE+1 clocks.
- pulled is never high on two consecutive cycles. lever_state changes only on a pulled cycle.
- Reset mid-operation (any state) returns to IDLE with lever_state=00; a button still held after reset release is debounced afresh from btn_db=0.

Test Plan (DEBOUNCE=4, defaults otherwise):
- Reset: assert rst low mid-press -> all outputs 0 immediately (asynchronous); state IDLE after release.
- Hover edges:
  - xpos=97, ypos=97 -> hover=1 one cycle later.
  - xpos=96 -> hover=0.
  - xpos=203, ypos=153 -> hover=1.
  - xpos=204 -> hover=0.
- Valid clicks: cursor (150,120); left high 10 cycles, then low.
  - Expect busy=1 from 5 cycles after the press.
  - Expect pulled=1 exactly 5 cycles after release and lever_state=01.
  - Repeat twice -> lever_state 10, then 00.
- Glitch: cursor (150,120), left high for 3 cycles only -> btn_db stays 0, busy=0, no pulled.
- Drag-in: press at (20,20), move to (150,120), release -> busy=1 throughout (WAIT_REL), no pulled, lever_state unchanged.
- Drag-out: press at (150,120), move to (300,300) before release -> WAIT_REL, no pulled on release, lever_state unchanged.
